// File: rtl/microtile_pkg.sv
// Shared types and constants for the micro-tile switch controller.
// Combinational helpers only; no latency, no backpressure.
package microtile_pkg;

   localparam int DEF_NUM_TILES     = 4;
   localparam int DEF_SEL_W         = 2;
   localparam int DEF_STABLE_CYCLES = 4;
   localparam int DEF_RESET_CYCLES  = 8;
   localparam int DEF_CNT_W         = 4;
   localparam int MAX_TILES         = 1 << DEF_SEL_W;

   typedef enum logic [2:0] {
      BOOT,
      RUN,
      QUIESCE,
      SWAP,
      RELEASE
   } state_t;

   function automatic logic [MAX_TILES-1:0] onehot(input logic [DEF_SEL_W-1:0] idx);
      logic [MAX_TILES-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/sel_sync_filter.sv
// Two-flop synchroniser on the raw select pins plus a saturating stability counter.
// Latency: sel_s 2 cycles after sel_in, stable STABLE_CYCLES later; no backpressure.
module sel_sync_filter #(
   parameter int SEL_W         = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SEL_W-1:0] sel_in,
   output logic [SEL_W-1:0] sel_s,
   output logic             stable
);

   localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);

   logic [SEL_W-1:0] sel_meta;
   logic [CNT_W-1:0] cnt;

   // The counter restarts on the same edge that loads a new value into sel_s.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_meta <= '0;
         sel_s    <= '0;
         cnt      <= '0;
      end else begin
         sel_meta <= sel_in;
         sel_s    <= sel_meta;
         if (sel_meta != sel_s) begin
            cnt <= '0;
         end else if (cnt != STABLE_MAX) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign stable = (cnt == STABLE_MAX);

endmodule

// File: rtl/microtile_switch_ctrl.sv
// Micro-tile sequencer: quiesce, gate, swap and release tiles on a filtered select change.
// Latency: outputs registered from next state; a switch holds out_valid low 2*RESET_CYCLES+1 cycles; no backpressure.
module microtile_switch_ctrl
   import microtile_pkg::*;
#(
   parameter int NUM_TILES     = DEF_NUM_TILES,
   parameter int SEL_W         = DEF_SEL_W,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [SEL_W-1:0]     sel_in,
   output logic [NUM_TILES-1:0] tile_ena,
   output logic [NUM_TILES-1:0] tile_rst_n,
   output logic [SEL_W-1:0]     out_sel,
   output logic                 out_valid,
   output logic                 busy,
   output logic                 switch_done
);

   // BOOT includes the post-reset cycle, so it compares one step further.
   localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(RESET_CYCLES);
   localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(RESET_CYCLES - 1);

   state_t               state, state_d;
   logic [CNT_W-1:0]     cnt, cnt_d;
   logic [SEL_W-1:0]     cur, cur_d;
   logic [SEL_W-1:0]     target, target_d;
   logic [SEL_W-1:0]     sel_s;
   logic                 stable;
   logic                 in_range;
   logic [MAX_TILES-1:0] oh_cur, oh_zero;
   logic [NUM_TILES-1:0] ena_d, rst_d;
   logic                 valid_d, busy_d, done_d;

   sel_sync_filter #(
      .SEL_W         (SEL_W),
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
   ) u_sel_sync_filter (
      .clk    (clk),
      .rst_n  (rst_n),
      .sel_in (sel_in),
      .sel_s  (sel_s),
      .stable (stable)
   );

   assign in_range = (int'(sel_s) < NUM_TILES);
   assign out_sel  = cur;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BOOT;
         cnt         <= '0;
         cur         <= '0;
         target      <= '0;
         tile_ena    <= '0;
         tile_rst_n  <= '0;
         out_valid   <= 1'b0;
         busy        <= 1'b1;
         switch_done <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         cur         <= cur_d;
         target      <= target_d;
         tile_ena    <= ena_d;
         tile_rst_n  <= rst_d;
         out_valid   <= valid_d;
         busy        <= busy_d;
         switch_done <= done_d;
      end
   end

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      cur_d    = cur;
      target_d = target;
      done_d   = 1'b0;
      case (state)
         BOOT: begin
            if (cnt == BOOT_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         RUN: begin
            if (stable && (sel_s != cur) && in_range) begin
               target_d = sel_s;
               cnt_d    = '0;
               state_d  = QUIESCE;
            end
         end
         QUIESCE: begin
            if (cnt == PHASE_LAST) begin
               state_d = SWAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         SWAP: begin
            cur_d   = target;
            cnt_d   = '0;
            state_d = RELEASE;
         end
         RELEASE: begin
            if (cnt == PHASE_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_d = BOOT;
            cnt_d   = '0;
            cur_d   = '0;
         end
      endcase

      // Outputs are decoded from the state being entered so they sit in flops.
      oh_cur  = onehot(cur_d);
      oh_zero = onehot('0);
      ena_d   = '0;
      rst_d   = '0;
      valid_d = 1'b0;
      busy_d  = 1'b1;
      case (state_d)
         BOOT: begin
            ena_d = oh_zero[NUM_TILES-1:0];
         end
         RUN: begin
            ena_d   = oh_cur[NUM_TILES-1:0];
            rst_d   = oh_cur[NUM_TILES-1:0];
            valid_d = 1'b1;
            busy_d  = 1'b0;
         end
         QUIESCE, RELEASE: begin
            ena_d = oh_cur[NUM_TILES-1:0];
         end
         default: begin
            ena_d = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_microtile_switch_ctrl.sv
// Randomised scoreboard bench for microtile_switch_ctrl with a timeline reference model.
module tb_microtile_switch_ctrl;

   localparam int NT = 3;
   localparam int SC = 4;
   localparam int RC = 8;

   typedef struct packed {
      logic [NT-1:0] ena;
      logic [NT-1:0] rstn;
      logic [1:0]    osel;
      logic          val;
      logic          busy;
      logic          done;
   } obs_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    sel_in;
   logic [NT-1:0] tile_ena;
   logic [NT-1:0] tile_rst_n;
   logic [1:0]    out_sel;
   logic          out_valid;
   logic          busy;
   logic          switch_done;

   int checks = 0;
   int errors = 0;

   obs_t exp_q[$];
   int   done_q[$];

   // Reference model: cycle index since reset, and the cycle a switch was committed.
   obs_t m_out;
   int   m_t, m_d, m_cur, m_tgt, m_s1, m_s2, m_age;
   bit   m_sw;

   microtile_switch_ctrl #(
      .NUM_TILES     (NT),
      .SEL_W         (2),
      .STABLE_CYCLES (SC),
      .RESET_CYCLES  (RC),
      .CNT_W         (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sel_in      (sel_in),
      .tile_ena    (tile_ena),
      .tile_rst_n  (tile_rst_n),
      .out_sel     (out_sel),
      .out_valid   (out_valid),
      .busy        (busy),
      .switch_done (switch_done)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_t   = 0;
      m_d   = 0;
      m_sw  = 1'b0;
      m_cur = 0;
      m_tgt = 0;
      m_s1  = 0;
      m_s2  = 0;
      m_age = 0;
      m_out = '0;
      m_out.busy = 1'b1;
   endtask

   // One clock edge: commit decision from the cycle that ended, then outputs of the new cycle.
   task automatic model_edge(input int pin);
      int e;
      bit fin;
      if (!m_sw && m_t > RC && m_age == SC && m_s2 != m_cur && m_s2 < NT) begin
         m_sw  = 1'b1;
         m_d   = m_t;
         m_tgt = m_s2;
      end
      m_t++;
      if (m_s1 != m_s2) m_age = 0;
      else if (m_age < SC) m_age++;
      m_s2 = m_s1;
      m_s1 = pin;

      m_out = '0;
      m_out.busy = 1'b1;
      fin = m_sw && (m_t - m_d == 2 * RC + 2);
      if (fin) begin
         m_cur = m_tgt;
         m_sw  = 1'b0;
      end
      if (m_t <= RC) begin
         m_out.ena = NT'(1);
      end else if (!m_sw) begin
         m_out.ena  = NT'(1 << m_cur);
         m_out.rstn = NT'(1 << m_cur);
         m_out.osel = 2'(m_cur);
         m_out.val  = 1'b1;
         m_out.busy = 1'b0;
         m_out.done = fin;
         if (fin) done_q.push_back(m_cur);
      end else begin
         e = m_t - m_d;
         if (e <= RC) begin
            m_out.ena  = NT'(1 << m_cur);
            m_out.osel = 2'(m_cur);
         end else if (e == RC + 1) begin
            m_out.osel = 2'(m_cur);
         end else begin
            m_out.ena  = NT'(1 << m_tgt);
            m_out.osel = 2'(m_tgt);
         end
      end
   endtask

   task automatic tick(input logic [1:0] s, input logic r);
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_edge(int'(sel_in));
      #1;
      sel_in = s;
      rst_n  = r;
      if (!r) model_reset();
      exp_q.push_back(m_out);
   endtask

   task automatic hold(input logic [1:0] s, input int n);
      for (int i = 0; i < n; i++) tick(s, 1'b1);
   endtask

   // Monitor: compares every cycle's outputs and each switch_done pulse against the queues.
   initial begin
      obs_t ex, ac;
      int   tg;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            ac = {tile_ena, tile_rst_n, out_sel, out_valid, busy, switch_done};
            checks++;
            if (ac !== ex) begin
               errors++;
               $display("FAIL outputs @%0t: got ena=%b rst_n=%b sel=%0d vld=%b busy=%b done=%b, expected ena=%b rst_n=%b sel=%0d vld=%b busy=%b done=%b",
                        $time, ac.ena, ac.rstn, ac.osel, ac.val, ac.busy, ac.done,
                        ex.ena, ex.rstn, ex.osel, ex.val, ex.busy, ex.done);
            end
         end
         if (switch_done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
               errors++;
               $display("FAIL switch_done @%0t: unexpected pulse with out_sel=%0d", $time, out_sel);
            end else begin
               tg = done_q.pop_front();
               if (int'(out_sel) != tg) begin
                  errors++;
                  $display("FAIL switch_target @%0t: got out_sel=%0d, expected %0d", $time, out_sel, tg);
               end
            end
         end
      end
   end

   initial begin
      logic [1:0] s;
      int         n;
      rst_n  = 1'b0;
      sel_in = 2'd0;
      model_reset();

      repeat (3) tick(2'd0, 1'b0);
      hold(2'd0, 20);                 // boot on tile 0, then run
      hold(2'd2, 30);                 // clean step to tile 2
      hold(2'd1, 2);                  // short glitch, filtered
      hold(2'd2, 15);
      hold(2'd3, 2);                  // out-of-range glitch
      hold(2'd2, 15);
      hold(2'd1, 18);                 // switch to 1, change back during RELEASE
      hold(2'd0, 50);
      hold(2'd3, 25);                 // out of range, ignored
      hold(2'd2, 10);                 // reset in the middle of QUIESCE
      tick(2'd2, 1'b0);
      hold(2'd2, 40);

      for (int seg = 0; seg < 40; seg++) begin
         s = 2'($urandom_range(0, 3));
         n = $urandom_range(1, 30);
         if ($urandom_range(0, 9) == 0) tick(s, 1'b0);
         hold(s, n);
      end
      hold(2'd0, 45);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL exp_queue: %0d entries left, expected 0", exp_q.size());
      end
      checks++;
      if (done_q.size() != 0) begin
         errors++;
         $display("FAIL done_queue: %0d switch_done pulses missing, expected 0", done_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
